ms_flip_flop: RTL and testbench

Master-slave SR flip-flop built from two gated SR latches in series: the master follows S/R while CLK is high, and the slave copies the master while CLK is low. Q therefore changes only at the falling edge of CLK. It is the storage primitive of the gated-latch lab datapath and sits directly behind the combinational set/reset logic.

---
 rtl/ms_flip_flop_pkg.sv | 7 +
 rtl/ms_flip_flop_latch.sv | 30 +++
 rtl/ms_flip_flop.sv | 44 ++++
 tb/tb_ms_flip_flop.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ms_flip_flop_pkg.sv
// Shared constants for the master-slave SR flip-flop.
package ms_flip_flop_pkg;

  // Default number of independent bit-slices.
  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/ms_flip_flop_latch.sv
// Gated SR latch: transparent while G=1, holds while G=0.
// RST has priority; S=R=1 is treated as hold so no X is produced.
module gated_sr_latch (
  input  logic G,
  input  logic S,
  input  logic R,
  input  logic RST,
  output logic Q,
  output logic Q_L
);

  logic r_q;

  // Level-sensitive storage: follows the request rules only while the gate is open.
  always_latch begin
    if (G) begin
      if (RST) begin
        r_q <= 1'b0;
      end else if (S && !R) begin
        r_q <= 1'b1;
      end else if (R && !S) begin
        r_q <= 1'b0;
      end
    end
  end

  assign Q   = r_q;
  assign Q_L = ~r_q;

endmodule

// File: rtl/ms_flip_flop.sv
// Master-slave SR flip-flop, WIDTH independent bit-slices.
// Master is open while CLK=1, slave while CLK=0, so Q moves only on CLK falling.
module ms_flip_flop
  import ms_flip_flop_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_L
);

  logic             w_clk_n;
  logic [WIDTH-1:0] w_m;
  logic [WIDTH-1:0] w_m_l;

  assign w_clk_n = ~CLK;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    // Master captures the port requests during the high phase.
    gated_sr_latch u_master (
      .G   (CLK),
      .S   (S[g]),
      .R   (R[g]),
      .RST (RST),
      .Q   (w_m[g]),
      .Q_L (w_m_l[g])
    );

    // Slave copies the master during the low phase; its reset is never used.
    gated_sr_latch u_slave (
      .G   (w_clk_n),
      .S   (w_m[g]),
      .R   (w_m_l[g]),
      .RST (1'b0),
      .Q   (Q[g]),
      .Q_L (Q_L[g])
    );
  end

endmodule

// File: tb/tb_ms_flip_flop.sv
// Directed bench for ms_flip_flop using a 2-bit instance to show slice independence.
module tb_ms_flip_flop;

  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic [W-1:0] q;
  logic [W-1:0] q_l;

  int n_checks;
  int n_fail;

  ms_flip_flop #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .S   (s),
    .R   (r),
    .Q   (q),
    .Q_L (q_l)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_q(input string tag, input logic [W-1:0] exp);
    check({tag, ".q"}, q, exp);
    check({tag, ".q_l"}, q_l, ~exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0; rst = 1'b0; s = '0; r = '0;
    #10;

    // Reset while a set is also requested: reset wins.
    clk = 1'b1; rst = 1'b1; s = 2'b11; r = 2'b00;
    #50;
    clk = 1'b0;
    #1 check_q("reset", 2'b00);
    rst = 1'b0; s = 2'b00;
    #49;

    // Set applied in the low phase, appears only at the falling edge.
    s = 2'b11;
    #50;
    clk = 1'b1;
    #1 check_q("set_rise", 2'b00);
    #49;
    clk = 1'b0;
    #1 check_q("set_fall", 2'b11);
    #49;

    // Hold then reset bit 0 only, R raised mid-high-phase.
    s = 2'b00; r = 2'b00;
    #50;
    clk = 1'b1;
    #1 check_q("hold_rise", 2'b11);
    #49;
    r = 2'b01;
    #1 check_q("reset_mid_high", 2'b11);
    #49;
    clk = 1'b0;
    #1 check_q("reset_bit0", 2'b10);
    #9;

    // Low-phase immunity: inputs toggle while CLK=0.
    s = 2'b11; r = 2'b00;
    #10 check_q("low_s", 2'b10);
    s = 2'b00; r = 2'b11;
    #10 check_q("low_r", 2'b10);
    rst = 1'b1;
    #10 check_q("low_rst", 2'b10);
    rst = 1'b0; r = 2'b00; s = 2'b01;
    #10;
    s = 2'b00;
    #10;
    // A request removed before CLK rises is lost.
    clk = 1'b1;
    #50;
    clk = 1'b0;
    #1 check_q("lost_req", 2'b10);
    #49;

    // Pulse capture: S pulses within the high phase.
    clk = 1'b1;
    #10 s = 2'b01;
    #10 s = 2'b00;
    #30;
    clk = 1'b0;
    #1 check_q("pulse", 2'b11);
    #49;

    // Forbidden S=R=1 holds.
    clk = 1'b1;
    s = 2'b11; r = 2'b11;
    #50;
    clk = 1'b0;
    #1 check_q("forbidden", 2'b11);
    s = 2'b00; r = 2'b00;
    #49;

    // Last request within the phase wins, per bit.
    clk = 1'b1;
    s = 2'b01; r = 2'b10;
    #20;
    s = 2'b10; r = 2'b01;
    #30;
    clk = 1'b0;
    #1 check_q("last_wins", 2'b10);
    s = 2'b00; r = 2'b00;
    #49;

    // Restore Q=11 for the priority case.
    clk = 1'b1; s = 2'b11;
    #50;
    clk = 1'b0;
    #1 check_q("restore", 2'b11);
    #49;

    // RST rises mid-phase with S still high: earlier capture is lost.
    clk = 1'b1;
    #20 rst = 1'b1;
    #1 check_q("rst_mid_high", 2'b11);
    #29;
    clk = 1'b0;
    #1 check_q("rst_priority", 2'b00);
    rst = 1'b0; s = 2'b00;
    #49;

    // Plain hold phase keeps the reset value.
    clk = 1'b1;
    #50;
    clk = 1'b0;
    #1 check_q("post_hold", 2'b00);
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
